// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the fetch PC and keeps one instruction-memory
// request in flight at a time. Each returned word is buffered for decode.
// A redirect, or a trap when PC_SEQ_TRAP_EN is defined, replaces the PC.
// If a fetch is already in flight, its word is discarded.
//
// state | meaning
// IDLE  | after reset; snapshot PC as the first fetch address
// REQ   | request presented to imem, waiting for acceptance
// WAIT  | request accepted, waiting for the response word
// HOLD  | instruction buffered, waiting for decode to take it
module pc_fetch_sequencer #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              ILEN         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
`ifdef PC_SEQ_TRAP_EN
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
`endif
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc_out,
  output logic            misalign_err
);

  localparam logic [XLEN-1:0] INCR       = XLEN'(ILEN / 8);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((ILEN / 8) - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] req_addr, req_addr_nxt;
  logic [XLEN-1:0] instr_pc_q, instr_pc_nxt;
  logic [ILEN-1:0] instr_q, instr_nxt;
  logic            kill, kill_nxt;
  logic            misalign_q, misalign_nxt;
  logic            jump_valid;
  logic [XLEN-1:0] jump_raw;
  logic [XLEN-1:0] jump_pc;

  // Pick the PC-changing event; a trap outranks a same-cycle redirect.
  always_comb begin
    jump_valid = redirect_valid;
    jump_raw   = redirect_target;
`ifdef PC_SEQ_TRAP_EN
    if (trap_req) begin
      jump_valid = 1'b1;
      jump_raw   = trap_vector;
    end
`endif
    jump_pc = jump_raw & ~ALIGN_MASK;
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      req_addr   <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      kill       <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_addr   <= req_addr_nxt;
      instr_q    <= instr_nxt;
      instr_pc_q <= instr_pc_nxt;
      kill       <= kill_nxt;
      misalign_q <= misalign_nxt;
    end
  end

  // Next-state, PC and kill logic.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    instr_nxt    = instr_q;
    instr_pc_nxt = instr_pc_q;
    kill_nxt     = kill;
    misalign_nxt = jump_valid && (|(jump_raw & ALIGN_MASK));
    if (jump_valid) pc_nxt = jump_pc;
    case (state)
      IDLE: begin
        // Snapshot the post-redirect PC so a redirect here is not lost.
        req_addr_nxt = pc_nxt;
        state_nxt    = REQ;
      end
      REQ: begin
        // The address is already on the bus, so it must stay put. Mark the word stale instead.
        if (jump_valid) kill_nxt = 1'b1;
        if (imem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (kill || jump_valid) begin
            kill_nxt     = 1'b0;
            req_addr_nxt = pc_nxt;
            state_nxt    = REQ;
          end else begin
            instr_nxt    = imem_resp_data;
            instr_pc_nxt = req_addr;
            pc_nxt       = req_addr + INCR;
            state_nxt    = HOLD;
          end
        end else if (jump_valid) begin
          kill_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (jump_valid || instr_ready) begin
          req_addr_nxt = pc_nxt;
          state_nxt    = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = (state == REQ) ? req_addr : '0;
  assign instr_valid    = (state == HOLD);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign pc_out         = pc;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_pc_fetch_sequencer;
  localparam logic [63:0] RV = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_target;
`ifdef PC_SEQ_TRAP_EN
  logic        trap_req;
  logic [63:0] trap_vector;
`endif
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic [63:0] pc_out;
  logic        misalign_err;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.XLEN(64), .RESET_VECTOR(RV), .ILEN(32)) dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
`ifdef PC_SEQ_TRAP_EN
    .trap_req(trap_req),
    .trap_vector(trap_vector),
`endif
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .pc_out(pc_out),
    .misalign_err(misalign_err)
  );

  int checks = 0;
  int failures = 0;
  int n_cons = 0;
  int cyc = 0;
  int lat_force = -1;
  bit spur_en = 1'b0;
  logic [63:0] exp_pc;
  logic        pend = 1'b0;
  logic [63:0] pend_addr;
  int          pend_lat;
  logic [63:0] acc_addr_q[$];
  int          acc_cyc_q[$];

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, apply the transaction model, then check after the edge.
  task automatic tick(input logic rv, input logic [63:0] rt, input logic rq_rdy, input logic in_rdy);
    logic        jv, accept, consume, hold_req, exp_mis;
    logic [63:0] jt, seen_addr;
    redirect_valid  = rv;
    redirect_target = rt;
    imem_req_ready  = rq_rdy;
    instr_ready     = in_rdy;
    if (pend && pend_lat == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr);
    end else begin
      imem_resp_valid = !pend && spur_en && ($urandom_range(0, 7) == 0);
      imem_resp_data  = $urandom;
    end
    jv = rv;
    jt = rt;
`ifdef PC_SEQ_TRAP_EN
    if (trap_req) begin
      jv = 1'b1;
      jt = trap_vector;
    end
`endif
    accept    = reset && (imem_req_valid === 1'b1) && rq_rdy;
    hold_req  = reset && (imem_req_valid === 1'b1) && !rq_rdy;
    consume   = reset && (instr_valid === 1'b1) && in_rdy && !jv;
    seen_addr = imem_addr;
    if (consume) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr_word", {32'h0, instr}, {32'h0, mem_word(exp_pc)});
      exp_pc = exp_pc + 64'd4;
      n_cons++;
    end
    exp_mis = reset && jv && (jt[1:0] != 2'b00);
    if (reset && jv) exp_pc = {jt[63:2], 2'b00};
    @(posedge clk);
    #1;
    cyc++;
    chk("misalign_err", 64'(misalign_err), 64'(exp_mis));
    if (hold_req) begin
      chk("req_held_valid", 64'(imem_req_valid), 64'd1);
      chk("req_held_addr", imem_addr, seen_addr);
    end
    if (reset && jv) chk("pc_after_redirect", pc_out, exp_pc);
    if (!reset) begin
      pend = 1'b0;
    end else begin
      if (pend && imem_resp_valid) pend = 1'b0;
      else if (pend) pend_lat--;
      if (accept) begin
        pend      = 1'b1;
        pend_addr = seen_addr;
        pend_lat  = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 2));
        acc_addr_q.push_back(seen_addr);
        acc_cyc_q.push_back(cyc);
      end
    end
  endtask

  task automatic wait_hold();
    int n = 0;
    while (instr_valid !== 1'b1 && n < 40) begin
      tick(1'b0, 64'h0, 1'b1, 1'b0);
      n++;
    end
    chk("wait_hold_timeout", 64'(instr_valid), 64'd1);
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, 64'h0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0] s_instr;
    logic [63:0] s_pc, a_old;
    int idx, n;
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    instr_ready = 1'b0;
    exp_pc = RV;
`ifdef PC_SEQ_TRAP_EN
    trap_req = 1'b0;
    trap_vector = '0;
`endif

    // Reset: outputs quiet, pc at the reset vector.
    repeat (3) tick(1'b0, 64'h0, 1'b1, 1'b1);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_imem_addr", imem_addr, 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    chk("rst_pc_out", pc_out, RV);
    reset = 1'b1;
    exp_pc = RV;

    // Sequential fetch, 1-cycle imem: 0x0, 0x4, 0x8 three cycles apart.
    lat_force = 0;
    run(12);
    chk("seq_acc_count", 64'(acc_addr_q.size() >= 3), 64'd1);
    chk("seq_addr0", acc_addr_q[0], 64'h0);
    chk("seq_addr1", acc_addr_q[1], 64'h4);
    chk("seq_addr2", acc_addr_q[2], 64'h8);
    chk("seq_gap01", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd3);
    chk("seq_gap12", 64'(acc_cyc_q[2] - acc_cyc_q[1]), 64'd3);

    // Decode stall in HOLD for 5 cycles.
    wait_hold();
    s_instr = instr;
    s_pc = instr_pc;
    repeat (5) begin
      tick(1'b0, 64'h0, 1'b1, 1'b0);
      chk("stall_valid", 64'(instr_valid), 64'd1);
      chk("stall_instr", 64'(instr), 64'(s_instr));
      chk("stall_pc", instr_pc, s_pc);
      chk("stall_no_req", 64'(imem_req_valid), 64'd0);
    end
    tick(1'b0, 64'h0, 1'b1, 1'b1);
    chk("stall_resume_req", 64'(imem_req_valid), 64'd1);

    // imem back-pressure with a redirect in the second stalled cycle.
    wait_hold();
    tick(1'b0, 64'h0, 1'b0, 1'b1);
    a_old = imem_addr;
    for (int i = 0; i < 4; i++)
      tick(i == 1, 64'h100, 1'b0, 1'b1);
    chk("bp_addr_held", imem_addr, a_old);
    idx = acc_addr_q.size();
    tick(1'b0, 64'h0, 1'b1, 1'b1);
    run(8);
    chk("bp_first_acc", acc_addr_q[idx], a_old);
    chk("bp_next_acc", acc_addr_q[idx+1], 64'h100);

    // Misaligned redirect.
    wait_hold();
    idx = acc_addr_q.size();
    tick(1'b1, 64'h203, 1'b1, 1'b0);
    run(6);
    chk("mis_next_fetch", acc_addr_q[idx], 64'h200);

    // Wrap at the top of the address space.
    wait_hold();
    idx = acc_addr_q.size();
    tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
    run(8);
    chk("wrap_top", acc_addr_q[idx], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_zero", acc_addr_q[idx+1], 64'h0);

`ifdef PC_SEQ_TRAP_EN
    // Trap beats a same-cycle redirect.
    wait_hold();
    idx = acc_addr_q.size();
    trap_req = 1'b1;
    trap_vector = 64'h8000;
    tick(1'b1, 64'h40, 1'b1, 1'b0);
    trap_req = 1'b0;
    run(6);
    chk("trap_priority", acc_addr_q[idx], 64'h8000);
`endif

    // Reset while waiting for a response.
    lat_force = 2;
    n = 0;
    while (!pend && n < 20) begin
      tick(1'b0, 64'h0, 1'b1, 1'b1);
      n++;
    end
    chk("wait_reached", 64'(pend), 64'd1);
    reset = 1'b0;
    tick(1'b0, 64'h0, 1'b1, 1'b1);
    chk("rst_wait_pc", pc_out, RV);
    chk("rst_wait_req", 64'(imem_req_valid), 64'd0);
    chk("rst_wait_ivalid", 64'(instr_valid), 64'd0);
    reset = 1'b1;
    exp_pc = RV;
    tick(1'b0, 64'h0, 1'b1, 1'b1);
    chk("rst_wait_req_again", 64'(imem_req_valid), 64'd1);
    chk("rst_wait_addr", imem_addr, RV);

    // Random traffic against the fetch-stream model.
    lat_force = -1;
    spur_en = 1'b1;
    n = n_cons;
    repeat (800) begin
      logic rv;
      logic [63:0] rt;
      rv = ($urandom_range(0, 15) == 0);
      rt = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 32'($urandom)} : {48'h0, 16'($urandom)};
      tick(rv, rt, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    spur_en = 1'b0;
    run(10);
    chk("random_progress", 64'(n_cons - n >= 30), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
